// File: rtl/button_press_decoder.sv
// Debounces an active-low pushbutton and classifies each press as short or long.
// Optional repeat of long_pulse while held when BTN_LONG_REPEAT_EN is defined.
//
// Ports:
//   int_osc     in   sole clock, rising edge
//   rst_n       in   synchronous active-low reset
//   btn_n_raw   in   asynchronous pin, low = pressed
//   btn_level   out  debounced state, 1 = pressed
//   short_pulse out  1-cycle strobe, press released before the long threshold
//   long_pulse  out  1-cycle strobe, hold reached the long threshold
//   press_count out  accepted presses, wraps 255 -> 0
module button_press_decoder #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int LONG_CYCLES     = 12000000
) (
  input  logic       int_osc,
  input  logic       rst_n,
  input  logic       btn_n_raw,
  output logic       btn_level,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } state_t;

  localparam logic [23:0] DEB_MAX  = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] LONG_MAX = 24'(LONG_CYCLES - 1);

  logic        sync_q1;
  logic        sync_q2;
  logic        sample;
  logic [23:0] deb_cnt;
  logic [23:0] deb_nx;
  logic        level_nx;
  logic        flip;
  logic        rise;
  logic        fall;

  state_t      state;
  state_t      state_nx;
  logic [23:0] hold_cnt;
  logic [23:0] hold_nx;
  logic        short_nx;
  logic        long_nx;
  logic [7:0]  count_nx;

  // sync flops carry the inverted pin so reset means "not pressed"
  assign sample = sync_q2;
  assign flip   = (sample != btn_level) && (deb_cnt == DEB_MAX);
  assign rise   = flip && !btn_level;
  assign fall   = flip && btn_level;

  always_comb begin
    deb_nx   = '0;
    level_nx = btn_level;
    if (flip) begin
      level_nx = ~btn_level;
    end else if (sample != btn_level) begin
      deb_nx = deb_cnt + 24'd1;
    end
  end

  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    short_nx = 1'b0;
    long_nx  = 1'b0;
    count_nx = press_count + {7'd0, rise};
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_nx = PRESSED;
          hold_nx  = '0;
        end
      end
      PRESSED: begin
        if (!btn_level) begin
          short_nx = 1'b1;
          state_nx = rise ? PRESSED : IDLE;
          hold_nx  = '0;
        end else if (hold_cnt == LONG_MAX && !fall) begin
          // a release landing on the threshold edge wins
          long_nx  = 1'b1;
          state_nx = LONG_HELD;
`ifdef BTN_LONG_REPEAT_EN
          hold_nx  = '0;
`else
          hold_nx  = hold_cnt + 24'd1;
`endif
        end else begin
          hold_nx = hold_cnt + 24'd1;
        end
      end
      LONG_HELD: begin
        if (!btn_level) begin
          state_nx = rise ? PRESSED : IDLE;
          hold_nx  = '0;
        end else begin
`ifdef BTN_LONG_REPEAT_EN
          if (hold_cnt == LONG_MAX && !fall) begin
            long_nx = 1'b1;
            hold_nx = '0;
          end else begin
            hold_nx = hold_cnt + 24'd1;
          end
`else
          if (hold_cnt != '1) begin
            hold_nx = hold_cnt + 24'd1;
          end
`endif
        end
      end
      default: begin
        state_nx = IDLE;
        hold_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge int_osc) begin
    if (!rst_n) begin
      sync_q1     <= 1'b0;
      sync_q2     <= 1'b0;
      deb_cnt     <= '0;
      btn_level   <= 1'b0;
      state       <= IDLE;
      hold_cnt    <= '0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      press_count <= '0;
    end else begin
      sync_q1     <= ~btn_n_raw;
      sync_q2     <= sync_q1;
      deb_cnt     <= deb_nx;
      btn_level   <= level_nx;
      state       <= state_nx;
      hold_cnt    <= hold_nx;
      short_pulse <= short_nx;
      long_pulse  <= long_nx;
      press_count <= count_nx;
    end
  end

endmodule

// File: tb/tb_button_press_decoder.sv
// Bench for button_press_decoder with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Event-level model checked every cycle, plus directed literal checks.
module tb_button_press_decoder;

  localparam int DEB = 4;
  localparam int LNG = 20;
`ifdef BTN_LONG_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic       int_osc = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_n_raw = 1'b1;
  logic       btn_level;
  logic       short_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  int vectors = 0;
  int errors = 0;

  always #5 int_osc = ~int_osc;

  button_press_decoder #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES(LNG)
  ) dut (
    .int_osc(int_osc),
    .rst_n(rst_n),
    .btn_n_raw(btn_n_raw),
    .btn_level(btn_level),
    .short_pulse(short_pulse),
    .long_pulse(long_pulse),
    .press_count(press_count)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: sampled-press history, streak of disagreeing samples,
  // and press timing measured in edges since the accepted rise
  bit         m_valid = 1'b0;
  bit         m_hist[$];
  bit         m_lvl;
  int         m_streak;
  bit         m_short;
  bit         m_long;
  bit         m_pend;
  bit         m_in;
  bit         m_seen;
  int         m_t;
  int         m_trise;
  logic [7:0] m_cnt;

  always @(posedge int_osc) begin
    logic samp;
    logic tog;
    logic rise_e;
    logic fall_e;
    int   age;
    if (!rst_n) begin
      m_valid  = 1'b1;
      m_hist   = {1'b0, 1'b0};
      m_lvl    = 1'b0;
      m_streak = 0;
      m_short  = 1'b0;
      m_long   = 1'b0;
      m_pend   = 1'b0;
      m_in     = 1'b0;
      m_seen   = 1'b0;
      m_t      = 0;
      m_trise  = 0;
      m_cnt    = 8'd0;
    end else if (m_valid) begin
      m_t++;
      samp = m_hist[0];
      m_hist.push_back(~btn_n_raw);
      void'(m_hist.pop_front());
      tog    = (samp != m_lvl) && (m_streak + 1 == DEB);
      rise_e = tog && !m_lvl;
      fall_e = tog && m_lvl;
      m_short = m_pend;
      m_pend  = 1'b0;
      m_long  = 1'b0;
      age = m_t - m_trise;
      if (m_in && m_lvl && !fall_e) begin
        if (REPEAT ? (age % LNG == 0) : (age == LNG && !m_seen)) begin
          m_long = 1'b1;
          m_seen = 1'b1;
        end
      end
      if (samp != m_lvl) m_streak++;
      else m_streak = 0;
      if (tog) begin
        m_lvl    = ~m_lvl;
        m_streak = 0;
      end
      if (fall_e) begin
        m_pend = !m_seen;
        m_in   = 1'b0;
      end
      if (rise_e) begin
        m_in    = 1'b1;
        m_seen  = 1'b0;
        m_trise = m_t;
        m_cnt   = m_cnt + 8'd1;
      end
    end
  end

  always @(negedge int_osc) begin
    if (m_valid) begin
      check("level", {31'd0, btn_level}, {31'd0, m_lvl});
      check("short", {31'd0, short_pulse}, {31'd0, m_short});
      check("long", {31'd0, long_pulse}, {31'd0, m_long});
      check("count", {24'd0, press_count}, {24'd0, m_cnt});
    end
  end

  int  cyc = 0;
  int  n_short = 0;
  int  n_long = 0;
  int  n_rise = 0;
  int  rise_cyc = 0;
  int  fall_cyc = 0;
  int  short_cyc = 0;
  int  first_long = -1;
  bit  prev_lvl = 1'b0;

  task automatic step();
    @(negedge int_osc);
    cyc++;
    if (short_pulse) begin
      n_short++;
      short_cyc = cyc;
    end
    if (long_pulse) begin
      n_long++;
      if (first_long < 0) first_long = cyc;
    end
    if (btn_level && !prev_lvl) begin
      n_rise++;
      rise_cyc = cyc;
    end
    if (!btn_level && prev_lvl) fall_cyc = cyc;
    prev_lvl = btn_level;
  endtask

  task automatic wait_level(input logic v, input string name);
    int k = 0;
    while (btn_level !== v && k < 20) begin
      step();
      k++;
    end
    check(name, {31'd0, btn_level}, {31'd0, v});
  endtask

  task automatic press(input int hold);
    btn_n_raw = 1'b0;
    wait_level(1'b1, "press_rise");
    repeat (hold) step();
    btn_n_raw = 1'b1;
    wait_level(1'b0, "press_fall");
    repeat (3) step();
  endtask

  int b_short;
  int b_long;
  int b_rise;

  initial begin
    // reset with button held, then debounce latency
    rst_n = 1'b0;
    btn_n_raw = 1'b0;
    repeat (3) step();
    check("rst_level", {31'd0, btn_level}, 32'd0);
    check("rst_short", {31'd0, short_pulse}, 32'd0);
    check("rst_long", {31'd0, long_pulse}, 32'd0);
    check("rst_count", {24'd0, press_count}, 32'd0);
    rst_n = 1'b1;
    repeat (5) step();
    check("deb_early", {31'd0, btn_level}, 32'd0);
    step();
    check("deb_latency", {31'd0, btn_level}, 32'd1);
    check("cnt_first", {24'd0, press_count}, 32'd1);

    // long hold
    b_short = n_short;
    b_long = n_long;
    first_long = -1;
    repeat (69) step();
    btn_n_raw = 1'b1;
    repeat (12) step();
    check("long_offset", first_long - rise_cyc, 32'd20);
    check("long_count", n_long - b_long, REPEAT ? 32'd3 : 32'd1);
    check("long_noshort", n_short - b_short, 32'd0);
    check("long_released", {31'd0, btn_level}, 32'd0);

    // glitch of 3 samples
    b_rise = n_rise;
    btn_n_raw = 1'b0;
    repeat (3) step();
    btn_n_raw = 1'b1;
    repeat (10) step();
    check("glitch_rise", n_rise - b_rise, 32'd0);
    check("glitch_cnt", {24'd0, press_count}, 32'd1);

    // short press
    b_short = n_short;
    b_long = n_long;
    press(10);
    check("short_count", n_short - b_short, 32'd1);
    check("short_nolong", n_long - b_long, 32'd0);
    check("short_delay", short_cyc - fall_cyc, 32'd1);
    check("short_cnt", {24'd0, press_count}, 32'd2);

    // release lands on the long threshold edge
    b_short = n_short;
    b_long = n_long;
    btn_n_raw = 1'b0;
    wait_level(1'b1, "thr_rise");
    repeat (14) step();
    btn_n_raw = 1'b1;
    wait_level(1'b0, "thr_fall");
    repeat (3) step();
    check("thr_fall_at", fall_cyc - rise_cyc, 32'd20);
    check("thr_short", n_short - b_short, 32'd1);
    check("thr_nolong", n_long - b_long, 32'd0);
    check("thr_cnt", {24'd0, press_count}, 32'd3);

    // reset mid-press at hold cycle 15
    btn_n_raw = 1'b0;
    wait_level(1'b1, "mid_rise");
    repeat (15) step();
    b_short = n_short;
    b_long = n_long;
    rst_n = 1'b0;
    repeat (2) step();
    check("mid_rst_level", {31'd0, btn_level}, 32'd0);
    check("mid_rst_cnt", {24'd0, press_count}, 32'd0);
    rst_n = 1'b1;
    repeat (5) step();
    check("mid_early", {31'd0, btn_level}, 32'd0);
    step();
    check("mid_reaccept", {31'd0, btn_level}, 32'd1);
    check("mid_cnt", {24'd0, press_count}, 32'd1);
    check("mid_noshort", n_short - b_short, 32'd0);
    check("mid_nolong", n_long - b_long, 32'd0);
    btn_n_raw = 1'b1;
    wait_level(1'b0, "mid_fall");
    repeat (3) step();

    // 256 short presses wrap the counter
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    b_short = n_short;
    b_long = n_long;
    for (int i = 0; i < 256; i++) press(2);
    check("wrap_cnt", {24'd0, press_count}, 32'd0);
    check("wrap_shorts", n_short - b_short, 32'd256);
    check("wrap_nolong", n_long - b_long, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
